// File: rtl/txll_frame_fifo.sv
// Single-clock frame-aware FIFO between the command/DMA side and the SATA TX link layer.
// First-word-fall-through read; optional store-and-forward hides partial frames.
module txll_frame_fifo #(
    parameter int C_DATA_WIDTH          = 36,
    parameter int C_EOF_BIT             = 34,
    parameter int C_ADDR_WIDTH          = 9,
    parameter int C_ALMOST_FULL_OFFSET  = 256,
    parameter int C_ALMOST_EMPTY_OFFSET = 128,
    parameter int C_STORE_FORWARD       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_DATA_WIDTH-1:0] wr_di,
    input  logic                    wr_en,
    input  logic                    wr_abort,
    output logic                    wr_full,
    output logic                    wr_almost_full,
    output logic [C_ADDR_WIDTH:0]   wr_count,
    output logic                    wr_err,
    output logic                    wr_eof_poped,
    output logic [C_DATA_WIDTH-1:0] rd_do,
    input  logic                    rd_en,
    output logic                    rd_empty,
    output logic                    rd_almost_empty,
    output logic [C_ADDR_WIDTH:0]   rd_count,
    output logic                    rd_err,
    output logic                    rd_eof_rdy,
    output logic [C_ADDR_WIDTH:0]   frm_count
);

    localparam int                  DEPTH   = 1 << C_ADDR_WIDTH;
    localparam logic [C_ADDR_WIDTH:0] DEPTH_V = (C_ADDR_WIDTH+1)'(DEPTH);
    localparam logic [C_ADDR_WIDTH:0] AF_OFF  = (C_ADDR_WIDTH+1)'(C_ALMOST_FULL_OFFSET);
    localparam logic [C_ADDR_WIDTH:0] AE_OFF  = (C_ADDR_WIDTH+1)'(C_ALMOST_EMPTY_OFFSET);
    localparam logic [C_ADDR_WIDTH:0] PTR_ONE = (C_ADDR_WIDTH+1)'(1);

    logic [C_DATA_WIDTH-1:0] mem [DEPTH];

    logic [C_ADDR_WIDTH:0] wr_ptr;
    logic [C_ADDR_WIDTH:0] wr_cmt;
    logic [C_ADDR_WIDTH:0] rd_ptr;
    logic [C_ADDR_WIDTH:0] frm_cnt;

    logic abort_sf;
    logic wr_ok;
    logic rd_ok;
    logic wr_eof;
    logic rd_eof;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign wr_count        = wr_ptr - rd_ptr;
    assign rd_count        = (C_STORE_FORWARD != 0) ? (wr_cmt - rd_ptr) : wr_count;
    assign wr_full         = (wr_count == DEPTH_V);
    assign wr_almost_full  = ((DEPTH_V - wr_count) <= AF_OFF);
    assign rd_empty        = (rd_count == '0);
    assign rd_almost_empty = (rd_count <= AE_OFF);
    assign rd_do           = mem[rd_ptr[C_ADDR_WIDTH-1:0]];
    assign rd_eof_rdy      = (frm_cnt != '0);
    assign frm_count       = frm_cnt;

    assign abort_sf = (C_STORE_FORWARD != 0) && wr_abort;
    assign wr_ok    = wr_en && !wr_full && !abort_sf;
    assign rd_ok    = rd_en && !rd_empty;
    assign wr_eof   = wr_ok && wr_di[C_EOF_BIT];
    assign rd_eof   = rd_ok && rd_do[C_EOF_BIT];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[C_ADDR_WIDTH-1:0]] <= wr_di;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            wr_cmt       <= '0;
            rd_ptr       <= '0;
            frm_cnt      <= '0;
            wr_err       <= 1'b0;
            rd_err       <= 1'b0;
            wr_eof_poped <= 1'b0;
        end else begin
            // Abort rewinds to the last frame boundary; any same-cycle write is dropped.
            if (abort_sf) begin
                wr_ptr <= wr_cmt;
            end else if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_eof) begin
                wr_cmt <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_eof, rd_eof})
                2'b10:   frm_cnt <= frm_cnt + PTR_ONE;
                2'b01:   frm_cnt <= frm_cnt - PTR_ONE;
                default: frm_cnt <= frm_cnt;
            endcase
            wr_err       <= wr_en && wr_full;
            rd_err       <= rd_en && rd_empty;
            wr_eof_poped <= rd_eof;
        end
    end

endmodule

// File: tb/tb_txll_frame_fifo.sv
// Drives a cut-through and a store-and-forward instance with identical stimulus and
// checks both against queue-based frame models every cycle.
module tb_txll_frame_fifo;

    localparam int W     = 36;
    localparam int EOFB  = 34;
    localparam int A     = 9;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] wr_di;
    logic         wr_en;
    logic         wr_abort;
    logic         rd_en;

    logic         o_wr_full [2];
    logic         o_wr_afull [2];
    logic [A:0]   o_wr_count [2];
    logic         o_wr_err [2];
    logic         o_eof_pop [2];
    logic [W-1:0] o_rd_do [2];
    logic         o_rd_empty [2];
    logic         o_rd_aempty [2];
    logic [A:0]   o_rd_count [2];
    logic         o_rd_err [2];
    logic         o_eof_rdy [2];
    logic [A:0]   o_frm [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    txll_frame_fifo #(.C_STORE_FORWARD(0)) u0 (
        .clk(clk), .rst(rst), .wr_di(wr_di), .wr_en(wr_en), .wr_abort(wr_abort),
        .wr_full(o_wr_full[0]), .wr_almost_full(o_wr_afull[0]), .wr_count(o_wr_count[0]),
        .wr_err(o_wr_err[0]), .wr_eof_poped(o_eof_pop[0]), .rd_do(o_rd_do[0]), .rd_en(rd_en),
        .rd_empty(o_rd_empty[0]), .rd_almost_empty(o_rd_aempty[0]), .rd_count(o_rd_count[0]),
        .rd_err(o_rd_err[0]), .rd_eof_rdy(o_eof_rdy[0]), .frm_count(o_frm[0])
    );

    txll_frame_fifo #(.C_STORE_FORWARD(1)) u1 (
        .clk(clk), .rst(rst), .wr_di(wr_di), .wr_en(wr_en), .wr_abort(wr_abort),
        .wr_full(o_wr_full[1]), .wr_almost_full(o_wr_afull[1]), .wr_count(o_wr_count[1]),
        .wr_err(o_wr_err[1]), .wr_eof_poped(o_eof_pop[1]), .rd_do(o_rd_do[1]), .rd_en(rd_en),
        .rd_empty(o_rd_empty[1]), .rd_almost_empty(o_rd_aempty[1]), .rd_count(o_rd_count[1]),
        .rd_err(o_rd_err[1]), .rd_eof_rdy(o_eof_rdy[1]), .frm_count(o_frm[1])
    );

    // Reference model: one queue of stored words per instance (index 0 = head).
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    bit exp_werr [2];
    bit exp_rerr [2];
    bit exp_pop [2];

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W-1:0] qget(input int m, input int i);
        return (m == 0) ? q0[i] : q1[i];
    endfunction

    task automatic qpush(input int m, input logic [W-1:0] w);
        if (m == 0) q0.push_back(w); else q1.push_back(w);
    endtask

    task automatic qpopf(input int m);
        if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qpopb(input int m);
        if (m == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    endtask

    task automatic qclear(input int m);
        if (m == 0) q0.delete(); else q1.delete();
    endtask

    // Words up to and including the last stored EOF form complete frames.
    function automatic int committed(input int m);
        logic [W-1:0] w;
        for (int i = qsize(m) - 1; i >= 0; i--) begin
            w = qget(m, i);
            if (w[EOFB]) return i + 1;
        end
        return 0;
    endfunction

    function automatic int readable(input int m);
        return (m == 0) ? qsize(m) : committed(m);
    endfunction

    function automatic int frames(input int m);
        logic [W-1:0] w;
        int f = 0;
        for (int i = 0; i < qsize(m); i++) begin
            w = qget(m, i);
            if (w[EOFB]) f++;
        end
        return f;
    endfunction

    task automatic chk(input int m, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL m%0d %s: got %0h expected %0h at %0t", m, name, act, exp, $time);
        end
    endtask

    task automatic check_and_step(input int m);
        int n, rd, f, part;
        bit rd_ok, wr_ok, sf;
        logic [W-1:0] head;
        n  = qsize(m);
        rd = readable(m);
        f  = frames(m);
        sf = (m == 1);
        chk(m, "wr_count", 64'(o_wr_count[m]), 64'(n));
        chk(m, "rd_count", 64'(o_rd_count[m]), 64'(rd));
        chk(m, "frm_count", 64'(o_frm[m]), 64'(f));
        chk(m, "rd_empty", 64'(o_rd_empty[m]), 64'(rd == 0));
        chk(m, "wr_full", 64'(o_wr_full[m]), 64'(n == DEPTH));
        chk(m, "wr_almost_full", 64'(o_wr_afull[m]), 64'((DEPTH - n) <= 256));
        chk(m, "rd_almost_empty", 64'(o_rd_aempty[m]), 64'(rd <= 128));
        chk(m, "rd_eof_rdy", 64'(o_eof_rdy[m]), 64'(f != 0));
        chk(m, "wr_err", 64'(o_wr_err[m]), 64'(exp_werr[m]));
        chk(m, "rd_err", 64'(o_rd_err[m]), 64'(exp_rerr[m]));
        chk(m, "wr_eof_poped", 64'(o_eof_pop[m]), 64'(exp_pop[m]));
        head = (n > 0) ? qget(m, 0) : '0;
        if (rd > 0) chk(m, "rd_do", 64'(o_rd_do[m]), 64'(head));

        if (rst) begin
            qclear(m);
            exp_werr[m] = 0;
            exp_rerr[m] = 0;
            exp_pop[m]  = 0;
        end else begin
            rd_ok = rd_en && (rd > 0);
            wr_ok = wr_en && (n < DEPTH) && !(wr_abort && sf);
            exp_werr[m] = wr_en && (n == DEPTH);
            exp_rerr[m] = rd_en && (rd == 0);
            exp_pop[m]  = rd_ok && head[EOFB];
            part = n - committed(m);
            if (rd_ok) qpopf(m);
            if (sf && wr_abort) begin
                for (int i = 0; i < part; i++) qpopb(m);
            end
            if (wr_ok) qpush(m, wr_di);
        end
    endtask

    bit running = 0;

    always @(negedge clk) begin
        if (running) begin
            check_and_step(0);
            check_and_step(1);
        end
    end

    function automatic logic [W-1:0] rw(input bit eof);
        logic [W-1:0] w;
        w = {4'($urandom()), $urandom()};
        w[EOFB] = eof;
        return w;
    endfunction

    task automatic drv(input bit we, input logic [W-1:0] d, input bit re, input bit ab);
        wr_en    = we;
        wr_di    = d;
        rd_en    = re;
        wr_abort = ab;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drv(0, '0, 0, 0);
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_di = '0; rd_en = 0; wr_abort = 0;
        @(posedge clk);
        #2;
        running = 1;
        idle(2);
        rst = 0;
        idle(2);

        // basic flow: 3-word frame then read it back
        for (int i = 0; i < 3; i++) drv(1, rw(i == 2), 0, 0);
        for (int i = 0; i < 3; i++) drv(0, '0, 1, 0);
        idle(3);

        // fill to full, overflow, read+write at full, abort, drain past empty
        for (int i = 0; i < DEPTH; i++) drv(1, rw(0), 0, 0);
        drv(1, rw(0), 0, 0);
        drv(1, rw(0), 1, 0);
        drv(0, '0, 0, 1);
        for (int i = 0; i < DEPTH + 3; i++) drv(0, '0, 1, 0);
        idle(2);

        // partial frame hidden until EOF
        for (int i = 0; i < 5; i++) drv(1, rw(0), 0, 0);
        idle(3);
        drv(1, rw(1), 0, 0);
        idle(1);
        for (int i = 0; i < 7; i++) drv(0, '0, 1, 0);

        // abort a partial frame together with an EOF write
        for (int i = 0; i < 4; i++) drv(1, rw(i == 3), 0, 0);
        for (int i = 0; i < 3; i++) drv(1, rw(0), 0, 0);
        drv(1, rw(1), 0, 1);
        idle(1);
        for (int i = 0; i < 10; i++) drv(0, '0, 1, 0);

        // EOF write and EOF read in the same cycle
        drv(1, rw(1), 0, 0);
        idle(1);
        drv(1, rw(1), 1, 0);
        idle(1);
        for (int i = 0; i < 3; i++) drv(0, '0, 1, 0);

        // reset with contents stored
        for (int i = 0; i < 10; i++) drv(1, rw(i == 4), 0, 0);
        rst = 1;
        idle(1);
        rst = 0;
        idle(2);

        // continuous streaming across pointer wrap
        for (int i = 0; i < 1500; i++) drv(1, rw($urandom_range(0, 7) == 0), 1, 0);
        for (int i = 0; i < 600; i++) drv(0, '0, 1, 0);

        // random mix, write-heavy then read-heavy
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 3) != 0, rw($urandom_range(0, 5) == 0),
                (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 40) == 0);
        end
        idle(3);

        @(negedge clk);
        #1;
        running = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
